// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// N-port front end for a single SDRAM master interface. One client port is
// granted per burst (round-robin or fixed priority). Its command is presented
// downstream until accepted, then write data / read data are routed between
// the granted port and the downstream side until the burst count runs out.

module sdram_port_arbiter #(
  parameter int NPORT = 2,
  parameter int DW    = 16,
  parameter int AW    = 24,
  parameter int BW    = 9,
  parameter int MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORT-1:0]      p_wr_req,
  input  logic [NPORT-1:0]      p_rd_req,
  input  logic [NPORT*AW-1:0]   p_address,
  input  logic [NPORT*BW-1:0]   p_burst_size,
  input  logic [NPORT*DW/8-1:0] p_byte_enable,
  input  logic [NPORT*DW-1:0]   p_wr_data,
  output logic [NPORT-1:0]      p_cmd_ack,
  output logic [NPORT-1:0]      p_wr_data_req,
  output logic [DW-1:0]         p_rd_data,
  output logic [NPORT-1:0]      p_rd_data_vld,
  output logic                  err_stray,
  output logic [AW-1:0]         m_address,
  output logic                  m_write,
  output logic                  m_read,
  output logic [BW-1:0]         m_burst_size,
  output logic [DW/8-1:0]       m_byte_enable,
  output logic [DW-1:0]         m_writedata,
  input  logic                  m_wr_data_req,
  input  logic [DW-1:0]         m_readdata,
  input  logic                  m_readdatavalid,
  input  logic                  m_rdy
);

  localparam int GW  = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int BEW = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Arbitration results (combinational, valid while IDLE)
  logic [NPORT-1:0] req_any;
  logic [7:0]       req_ext;
  logic [3:0]       scan_start;
  logic [3:0]       scan_sum;
  logic [2:0]       scan_idx;
  logic             win_found;
  logic [GW-1:0]    win_idx;
  logic             win_write;
  logic [AW-1:0]    win_addr;
  logic [BW-1:0]    win_burst;
  logic [BEW-1:0]   win_be;

  // Latched command of the granted port
  logic [GW-1:0]    grant_q;
  logic             cmd_write_q;
  logic [AW-1:0]    addr_q;
  logic [BW-1:0]    burst_q;
  logic [BEW-1:0]   be_q;
  logic [BW-1:0]    beat_cnt;
  logic [GW-1:0]    rr_ptr;

  logic             burst_done;
  logic [DW-1:0]    wr_data_sel;

  // Pick the winning port: scan from the round-robin pointer (or from port 0
  // in fixed-priority mode) and take the first port with any request pending.
  always_comb begin
    req_any    = p_wr_req | p_rd_req;
    req_ext    = 8'(req_any);
    scan_start = (MODE == 0) ? 4'(rr_ptr) : 4'd0;
    scan_sum   = '0;
    scan_idx   = '0;
    win_found  = 1'b0;
    win_idx    = '0;
    for (int k = 0; k < NPORT; k++) begin
      scan_sum = scan_start + 4'(k);
      if (scan_sum >= 4'(NPORT)) scan_sum = scan_sum - 4'(NPORT);
      scan_idx = scan_sum[2:0];
      if (!win_found && req_ext[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(scan_idx);
      end
    end
  end

  // Gather the winner's command fields; a write request beats a read request.
  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_burst = '0;
    win_be    = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (win_idx == GW'(i)) begin
        win_write = p_wr_req[i];
        win_addr  = p_address[i*AW +: AW];
        win_burst = p_burst_size[i*BW +: BW];
        win_be    = p_byte_enable[i*BEW +: BEW];
      end
    end
  end

  // Select the granted port's write data for the downstream bus.
  always_comb begin
    wr_data_sel = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (grant_q == GW'(i)) wr_data_sel = p_wr_data[i*DW +: DW];
    end
  end

  // The beat that brings the counter from 1 to 0 closes the burst.
  always_comb begin
    burst_done = 1'b0;
    if (beat_cnt == BW'(1)) begin
      if (state == WDATA && m_wr_data_req)   burst_done = 1'b1;
      if (state == RDATA && m_readdatavalid) burst_done = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus all per-state routing and strobes.
  always_comb begin
    state_nxt     = state;
    m_write       = 1'b0;
    m_read        = 1'b0;
    m_writedata   = '0;
    p_rd_data     = '0;
    p_cmd_ack     = '0;
    p_wr_data_req = '0;
    p_rd_data_vld = '0;
    case (state)
      IDLE: begin
        if (win_found) state_nxt = CMD;
      end
      CMD: begin
        m_write = cmd_write_q;
        m_read  = !cmd_write_q;
        if (m_rdy) begin
          for (int i = 0; i < NPORT; i++) begin
            if (grant_q == GW'(i)) p_cmd_ack[i] = 1'b1;
          end
          state_nxt = cmd_write_q ? WDATA : RDATA;
        end
      end
      WDATA: begin
        m_writedata = wr_data_sel;
        for (int i = 0; i < NPORT; i++) begin
          if (grant_q == GW'(i)) p_wr_data_req[i] = m_wr_data_req;
        end
        if (burst_done) state_nxt = IDLE;
      end
      RDATA: begin
        p_rd_data = m_readdata;
        for (int i = 0; i < NPORT; i++) begin
          if (grant_q == GW'(i)) p_rd_data_vld[i] = m_readdatavalid;
        end
        if (burst_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the grant and command, run the beat counter, advance the RR pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      cmd_write_q <= 1'b0;
      addr_q      <= '0;
      burst_q     <= '0;
      be_q        <= '0;
      beat_cnt    <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_q     <= win_idx;
            cmd_write_q <= win_write;
            addr_q      <= win_addr;
            burst_q     <= (win_burst == '0) ? BW'(1) : win_burst;
            be_q        <= win_be;
          end
        end
        CMD: begin
          if (m_rdy) beat_cnt <= burst_q;
        end
        WDATA: begin
          if (m_wr_data_req) beat_cnt <= beat_cnt - BW'(1);
        end
        RDATA: begin
          if (m_readdatavalid) beat_cnt <= beat_cnt - BW'(1);
        end
        default: ;
      endcase
      if (burst_done && MODE == 0) begin
        if (grant_q == GW'(NPORT - 1)) rr_ptr <= '0;
        else                           rr_ptr <= grant_q + GW'(1);
      end
    end
  end

  // Sticky flag for read data arriving when no read burst is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    err_stray <= 1'b0;
    else if (m_readdatavalid && state != RDATA)    err_stray <= 1'b1;
  end

  assign m_address     = addr_q;
  assign m_burst_size  = burst_q;
  assign m_byte_enable = be_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: one round-robin instance and one
// fixed-priority instance share the same stimulus.

module tb_sdram_port_arbiter;

  localparam int NPORT = 2;
  localparam int DW    = 16;
  localparam int AW    = 24;
  localparam int BW    = 9;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NPORT-1:0]      p_wr_req;
  logic [NPORT-1:0]      p_rd_req;
  logic [NPORT*AW-1:0]   p_address;
  logic [NPORT*BW-1:0]   p_burst_size;
  logic [NPORT*DW/8-1:0] p_byte_enable;
  logic [NPORT*DW-1:0]   p_wr_data;
  logic                  m_wr_data_req;
  logic [DW-1:0]         m_readdata;
  logic                  m_readdatavalid;
  logic                  m_rdy;

  logic [NPORT-1:0]  rr_cmd_ack, rr_wr_data_req, rr_rd_data_vld;
  logic [DW-1:0]     rr_rd_data, rr_writedata;
  logic              rr_err_stray, rr_write, rr_read;
  logic [AW-1:0]     rr_address;
  logic [BW-1:0]     rr_burst_size;
  logic [DW/8-1:0]   rr_byte_enable;

  logic [NPORT-1:0]  fp_cmd_ack, fp_wr_data_req, fp_rd_data_vld;
  logic [DW-1:0]     fp_rd_data, fp_writedata;
  logic              fp_err_stray, fp_write, fp_read;
  logic [AW-1:0]     fp_address;
  logic [BW-1:0]     fp_burst_size;
  logic [DW/8-1:0]   fp_byte_enable;

  int checks   = 0;
  int failures = 0;

  sdram_port_arbiter #(.NPORT(NPORT), .DW(DW), .AW(AW), .BW(BW), .MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .p_wr_req(p_wr_req), .p_rd_req(p_rd_req), .p_address(p_address),
    .p_burst_size(p_burst_size), .p_byte_enable(p_byte_enable), .p_wr_data(p_wr_data),
    .p_cmd_ack(rr_cmd_ack), .p_wr_data_req(rr_wr_data_req), .p_rd_data(rr_rd_data),
    .p_rd_data_vld(rr_rd_data_vld), .err_stray(rr_err_stray),
    .m_address(rr_address), .m_write(rr_write), .m_read(rr_read),
    .m_burst_size(rr_burst_size), .m_byte_enable(rr_byte_enable), .m_writedata(rr_writedata),
    .m_wr_data_req(m_wr_data_req), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .m_rdy(m_rdy)
  );

  sdram_port_arbiter #(.NPORT(NPORT), .DW(DW), .AW(AW), .BW(BW), .MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p_wr_req(p_wr_req), .p_rd_req(p_rd_req), .p_address(p_address),
    .p_burst_size(p_burst_size), .p_byte_enable(p_byte_enable), .p_wr_data(p_wr_data),
    .p_cmd_ack(fp_cmd_ack), .p_wr_data_req(fp_wr_data_req), .p_rd_data(fp_rd_data),
    .p_rd_data_vld(fp_rd_data_vld), .err_stray(fp_err_stray),
    .m_address(fp_address), .m_write(fp_write), .m_read(fp_read),
    .m_burst_size(fp_burst_size), .m_byte_enable(fp_byte_enable), .m_writedata(fp_writedata),
    .m_wr_data_req(m_wr_data_req), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .m_rdy(m_rdy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log a miss.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Load one port's request fields.
  task automatic applyStimulus(input int port, input logic wr, input logic rd,
                               input logic [AW-1:0] addr, input logic [BW-1:0] burst,
                               input logic [DW-1:0] wdata);
    p_wr_req[port]                 = wr;
    p_rd_req[port]                 = rd;
    p_address[port*AW +: AW]       = addr;
    p_burst_size[port*BW +: BW]    = burst;
    p_wr_data[port*DW +: DW]       = wdata;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle;
    #2;
  endtask

  task automatic clearInputs;
    p_wr_req        = '0;
    p_rd_req        = '0;
    p_address       = '0;
    p_burst_size    = '0;
    p_byte_enable   = '1;
    p_wr_data       = '0;
    m_wr_data_req   = 1'b0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;
    m_rdy           = 1'b1;
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a command ack on the chosen instance.
  task automatic waitAck(input bit use_fp, output logic [1:0] ack);
    ack = '0;
    for (int n = 0; n < 12; n++) begin
      settle();
      ack = use_fp ? fp_cmd_ack : rr_cmd_ack;
      if (ack != '0) break;
      cyc();
    end
  endtask

  // Hard stop if something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] ack;
    logic [4:0] pat;

    // Reset state
    rst_n = 1'b0;
    clearInputs();
    #3;
    checkOutput("rst_m_write",   32'(rr_write), 32'h0);
    checkOutput("rst_m_read",    32'(rr_read), 32'h0);
    checkOutput("rst_cmd_ack",   32'(rr_cmd_ack), 32'h0);
    checkOutput("rst_err_stray", 32'(rr_err_stray), 32'h0);
    checkOutput("rst_m_address", 32'(rr_address), 32'h0);
    doReset();

    // 1: single write, port 0, burst 4
    $display("[TB] test 1: single write burst");
    applyStimulus(0, 1'b1, 1'b0, 24'h000100, 9'd4, 16'h1234);
    settle();
    checkOutput("t1_idle_no_write", 32'(rr_write), 32'h0);
    cyc(); settle();
    checkOutput("t1_m_write",      32'(rr_write), 32'h1);
    checkOutput("t1_m_address",    32'(rr_address), 32'h000100);
    checkOutput("t1_m_burst",      32'(rr_burst_size), 32'd4);
    checkOutput("t1_m_be",         32'(rr_byte_enable), 32'h3);
    checkOutput("t1_ack",          32'(rr_cmd_ack), 32'h1);
    p_wr_req = '0;
    cyc(); settle();
    checkOutput("t1_ack_pulse",    32'(rr_cmd_ack), 32'h0);
    pat = 5'b11101;
    for (int i = 0; i < 5; i++) begin
      m_wr_data_req = pat[i];
      settle();
      checkOutput("t1_wr_data_req", 32'(rr_wr_data_req), 32'({1'b0, pat[i]}));
      checkOutput("t1_writedata",   32'(rr_writedata), 32'h1234);
      cyc();
    end
    m_wr_data_req = 1'b1;
    settle();
    checkOutput("t1_idle_wr_req",  32'(rr_wr_data_req), 32'h0);
    checkOutput("t1_idle_wdata",   32'(rr_writedata), 32'h0);

    // 2: round-robin alternation
    $display("[TB] test 2: round robin");
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 24'h000010, 9'd2, 16'h1111);
    applyStimulus(1, 1'b1, 1'b0, 24'h000020, 9'd2, 16'h2222);
    m_wr_data_req = 1'b1;
    for (int r = 0; r < 6; r++) begin
      waitAck(1'b0, ack);
      checkOutput("t2_rr_grant", 32'(ack), (r % 2 == 0) ? 32'h1 : 32'h2);
      cyc(); settle();
      checkOutput("t2_rr_wdata", 32'(rr_writedata), (r % 2 == 0) ? 32'h1111 : 32'h2222);
      cyc();
      cyc();
    end

    // 3: fixed priority starvation then release
    $display("[TB] test 3: fixed priority");
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 24'h000010, 9'd2, 16'h1111);
    applyStimulus(1, 1'b1, 1'b0, 24'h000020, 9'd2, 16'h2222);
    m_wr_data_req = 1'b1;
    for (int r = 0; r < 3; r++) begin
      waitAck(1'b1, ack);
      checkOutput("t3_fp_port0", 32'(ack), 32'h1);
      cyc();
      if (r == 2) p_wr_req[0] = 1'b0;
      cyc();
      cyc();
    end
    waitAck(1'b1, ack);
    checkOutput("t3_fp_port1", 32'(ack), 32'h2);

    // 4: port 1 read burst 8 plus a stray beat
    $display("[TB] test 4: read burst and stray beat");
    doReset();
    applyStimulus(1, 1'b0, 1'b1, 24'h000200, 9'd8, 16'h0000);
    settle();
    checkOutput("t4_idle_no_read", 32'(rr_read), 32'h0);
    cyc(); settle();
    checkOutput("t4_m_read",  32'(rr_read), 32'h1);
    checkOutput("t4_m_write", 32'(rr_write), 32'h0);
    checkOutput("t4_ack",     32'(rr_cmd_ack), 32'h2);
    checkOutput("t4_m_burst", 32'(rr_burst_size), 32'd8);
    p_rd_req = '0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        m_readdatavalid = 1'b0;
        settle();
        checkOutput("t4_gap_vld", 32'(rr_rd_data_vld), 32'h0);
        cyc();
      end
      m_readdatavalid = 1'b1;
      m_readdata      = 16'hA5A0 + 16'(i);
      settle();
      checkOutput("t4_rd_vld",  32'(rr_rd_data_vld), 32'h2);
      checkOutput("t4_rd_data", 32'(rr_rd_data), 32'hA5A0 + 32'(i));
      cyc();
    end
    m_readdatavalid = 1'b0;
    settle();
    checkOutput("t4_no_stray_yet", 32'(rr_err_stray), 32'h0);
    m_readdatavalid = 1'b1;
    settle();
    checkOutput("t4_stray_vld", 32'(rr_rd_data_vld), 32'h0);
    cyc();
    m_readdatavalid = 1'b0;
    settle();
    checkOutput("t4_err_stray", 32'(rr_err_stray), 32'h1);

    // 5: m_rdy stall in CMD
    $display("[TB] test 5: command stall");
    doReset();
    m_rdy = 1'b0;
    applyStimulus(0, 1'b0, 1'b1, 24'h123456, 9'd3, 16'h0000);
    cyc();
    p_address[0 +: AW] = 24'hFFFFFF;
    for (int n = 0; n < 5; n++) begin
      settle();
      checkOutput("t5_stall_read",  32'(rr_read), 32'h1);
      checkOutput("t5_stall_addr",  32'(rr_address), 32'h123456);
      checkOutput("t5_stall_burst", 32'(rr_burst_size), 32'd3);
      checkOutput("t5_stall_ack",   32'(rr_cmd_ack), 32'h0);
      cyc();
    end
    m_rdy = 1'b1;
    settle();
    checkOutput("t5_ack", 32'(rr_cmd_ack), 32'h1);
    p_rd_req = '0;
    cyc();
    m_readdatavalid = 1'b1;
    repeat (3) cyc();
    m_readdatavalid = 1'b0;
    settle();
    checkOutput("t5_done_read", 32'(rr_read), 32'h0);

    // 6: reset mid-burst, then a zero-length burst
    $display("[TB] test 6: reset mid burst");
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 24'h000300, 9'd8, 16'hBEEF);
    cyc(); settle();
    checkOutput("t6_ack", 32'(rr_cmd_ack), 32'h1);
    p_wr_req = '0;
    cyc();
    m_wr_data_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput("t6_beat", 32'(rr_wr_data_req), 32'h1);
      cyc();
    end
    settle();
    checkOutput("t6_pre_rst_wdata", 32'(rr_writedata), 32'hBEEF);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_wdata",   32'(rr_writedata), 32'h0);
    checkOutput("t6_rst_wr_req",  32'(rr_wr_data_req), 32'h0);
    checkOutput("t6_rst_address", 32'(rr_address), 32'h0);
    checkOutput("t6_rst_burst",   32'(rr_burst_size), 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    m_wr_data_req = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 24'h000400, 9'd0, 16'hCAFE);
    settle();
    checkOutput("t6_idle_ack", 32'(rr_cmd_ack), 32'h0);
    cyc(); settle();
    checkOutput("t6_z_write", 32'(rr_write), 32'h1);
    checkOutput("t6_z_burst", 32'(rr_burst_size), 32'd1);
    checkOutput("t6_z_addr",  32'(rr_address), 32'h000400);
    checkOutput("t6_z_ack",   32'(rr_cmd_ack), 32'h1);
    p_wr_req = '0;
    cyc();
    m_wr_data_req = 1'b1;
    settle();
    checkOutput("t6_z_beat",  32'(rr_wr_data_req), 32'h1);
    cyc(); settle();
    checkOutput("t6_z_idle",  32'(rr_wr_data_req), 32'h0);
    checkOutput("t6_z_no_wr", 32'(rr_write), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
